// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port synchronous data memory between the CPU load/store
//   path, the turtle line-draw engine and the VGA scan-out reader. One access
//   is granted per cycle. Read data comes back one cycle after the grant,
//   tagged to whoever asked for it. The CPU is stalled while it is denied.
//
// Parameters
//   ADDR_W   memory word-address width
//   DATA_W   memory data width
//   MAX_WAIT consecutive denied CPU cycles after which the CPU outranks draw
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   cpu_*                  CPU request/grant/stall/read-valid
//   draw_*                 draw-engine request (with burst lock) and grant
//   vga_*                  VGA read request, grant and read-valid
//   rdata                  shared read data (mem_q, held between reads)
//   mem_addr/we/wdata/q    block-RAM side
//
// Optional build macro DMEM_ARB_STATS_EN
//   Adds the grant/stall statistics counters and their stat_clr input.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    input  logic              draw_lock,
    output logic              draw_gnt,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] rdata,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_cpu_grants,
    output logic [15:0]       stat_draw_grants,
    output logic [15:0]       stat_vga_grants,
    output logic [15:0]       stat_cpu_stalls,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2,
        OWN_DRAW = 2'd3
    } owner_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic              rr_ptr_r;     // 0: CPU wins the next tie
    logic              lock_own_r;
    logic [3:0]        wait_cnt_r;
    owner_e            tag_r;
    logic [DATA_W-1:0] rdata_r;
    logic [ADDR_W-1:0] last_addr_r;

    logic              cpu_gnt_s, draw_gnt_s, vga_gnt_s, cpu_stall_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;
    owner_e            tag_nxt_s;
    logic              rr_nxt_s, lock_nxt_s;
    logic [3:0]        wait_nxt_s;

    // Priority grant; everything is gated off while reset is held low.
    always_comb begin
        cpu_gnt_s  = 1'b0;
        draw_gnt_s = 1'b0;
        vga_gnt_s  = 1'b0;
        if (!reset) begin
            vga_gnt_s = 1'b0;
        end else if (vga_req) begin
            vga_gnt_s = 1'b1;
        end else if (cpu_req && (wait_cnt_r >= MAX_WAIT_C)) begin
            cpu_gnt_s = 1'b1;
        end else if (lock_own_r && draw_req) begin
            draw_gnt_s = 1'b1;
        end else if (cpu_req && !draw_req) begin
            cpu_gnt_s = 1'b1;
        end else if (draw_req && !cpu_req) begin
            draw_gnt_s = 1'b1;
        end else if (cpu_req && draw_req) begin
            cpu_gnt_s  = ~rr_ptr_r;
            draw_gnt_s = rr_ptr_r;
        end else begin
            cpu_gnt_s = 1'b0;
        end
        cpu_stall_s = reset & cpu_req & ~cpu_gnt_s;
    end

    // Memory-side mux and read-owner tag for the granted requester.
    always_comb begin
        mem_addr_s  = last_addr_r;
        mem_we_s    = 1'b0;
        mem_wdata_s = {DATA_W{1'b0}};
        tag_nxt_s   = OWN_NONE;
        if (vga_gnt_s) begin
            mem_addr_s = vga_addr;
            tag_nxt_s  = OWN_VGA;
        end else if (cpu_gnt_s) begin
            mem_addr_s  = cpu_addr;
            mem_we_s    = cpu_we;
            mem_wdata_s = cpu_wdata;
            tag_nxt_s   = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (draw_gnt_s) begin
            mem_addr_s  = draw_addr;
            mem_we_s    = draw_we;
            mem_wdata_s = draw_wdata;
            tag_nxt_s   = draw_we ? OWN_NONE : OWN_DRAW;
        end else begin
            tag_nxt_s = OWN_NONE;
        end
    end

    // Next values for round-robin pointer, burst lock and starvation counter.
    always_comb begin
        rr_nxt_s   = rr_ptr_r;
        lock_nxt_s = lock_own_r;
        wait_nxt_s = wait_cnt_r;
        if (cpu_gnt_s) begin
            rr_nxt_s = 1'b1;
        end else if (draw_gnt_s) begin
            rr_nxt_s = 1'b0;
        end else begin
            rr_nxt_s = rr_ptr_r;
        end
        // Preemption by VGA or a starved CPU leaves the lock standing.
        if (!draw_req || !draw_lock) begin
            lock_nxt_s = 1'b0;
        end else if (draw_gnt_s) begin
            lock_nxt_s = 1'b1;
        end else begin
            lock_nxt_s = lock_own_r;
        end
        if (!cpu_req || cpu_gnt_s) begin
            wait_nxt_s = 4'd0;
        end else if (cpu_stall_s && (wait_cnt_r != 4'd15)) begin
            wait_nxt_s = wait_cnt_r + 4'd1;
        end else begin
            wait_nxt_s = wait_cnt_r;
        end
    end

    // Arbitration state, read tag and read-data holding register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r    <= 1'b0;
            lock_own_r  <= 1'b0;
            wait_cnt_r  <= 4'd0;
            tag_r       <= OWN_NONE;
            rdata_r     <= {DATA_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
        end else begin
            rr_ptr_r    <= rr_nxt_s;
            lock_own_r  <= lock_nxt_s;
            wait_cnt_r  <= wait_nxt_s;
            tag_r       <= tag_nxt_s;
            last_addr_r <= mem_addr_s;
            if (tag_r != OWN_NONE) begin
                rdata_r <= mem_q;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // mem_q is only valid in the cycle after the read address, so rdata
    // follows it directly then and holds the captured copy afterwards.
    assign rdata      = (tag_r != OWN_NONE) ? mem_q : rdata_r;
    assign cpu_rvalid = (tag_r == OWN_CPU);
    assign vga_rvalid = (tag_r == OWN_VGA);
    assign cpu_gnt    = cpu_gnt_s;
    assign draw_gnt   = draw_gnt_s;
    assign vga_gnt    = vga_gnt_s;
    assign cpu_stall  = cpu_stall_s;
    assign mem_addr   = mem_addr_s;
    assign mem_we     = mem_we_s;
    assign mem_wdata  = mem_wdata_s;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] st_cpu_r, st_draw_r, st_vga_r, st_stall_r;

    // Grant counters wrap, the stall counter saturates; stat_clr wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_cpu_r   <= 16'd0;
            st_draw_r  <= 16'd0;
            st_vga_r   <= 16'd0;
            st_stall_r <= 16'd0;
        end else if (stat_clr) begin
            st_cpu_r   <= 16'd0;
            st_draw_r  <= 16'd0;
            st_vga_r   <= 16'd0;
            st_stall_r <= 16'd0;
        end else begin
            st_cpu_r  <= st_cpu_r + {15'd0, cpu_gnt_s};
            st_draw_r <= st_draw_r + {15'd0, draw_gnt_s};
            st_vga_r  <= st_vga_r + {15'd0, vga_gnt_s};
            if (cpu_stall_s && (st_stall_r != 16'hFFFF)) begin
                st_stall_r <= st_stall_r + 16'd1;
            end else begin
                st_stall_r <= st_stall_r;
            end
        end
    end

    assign stat_cpu_grants  = st_cpu_r;
    assign stat_draw_grants = st_draw_r;
    assign stat_vga_grants  = st_vga_r;
    assign stat_cpu_stalls  = st_stall_r;
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data memory between three requesters:
  - the processor load/store path, driven from the control unit's mem_we and load decode;
  - the turtle line-draw engine, which writes pixels;
  - the VGA scan-out reader.
- Grants one access per cycle and returns read data one cycle later, tagged to the owner.
- Stalls the processor while it is denied.
- Sits between processor, draw engine, VGA controller and the dmem block RAM.

Parameters:
- ADDR_W, 12, memory word-address width.
- DATA_W, 32, memory data width.
- MAX_WAIT, 4, number of consecutive denied CPU cycles after which the CPU outranks the draw engine (range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  in  1  CPU access request, i.e. load or mem_we.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_stall  out  1  equals cpu_req & ~cpu_gnt; freezes the PC and pipeline.
- cpu_rvalid  out  1  cpu_rdata valid, one cycle after a CPU read grant.
- draw_req, draw_we, draw_addr, draw_wdata  in  1/1/ADDR_W/DATA_W  draw-engine request, same meanings as the CPU inputs.
- draw_lock  in  1  draw engine asks to keep ownership for a burst.
- draw_gnt  out  1  draw access accepted.
- vga_req  in  1  VGA read request (read only).
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  VGA access accepted.
- vga_rvalid  out  1  VGA read data valid.
- rdata  out  DATA_W  registered copy of mem_q, shared by all requesters.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_q  in  DATA_W  memory read data, valid one cycle after the address.

Behaviour:
- Grants are combinational from the current requests plus registered state:
  - rr_ptr, the round-robin pointer between CPU and draw;
  - lock_own, which is set while draw holds the lock;
  - wait_cnt, a 4-bit counter.
- At most one grant per cycle.
- mem_addr, mem_we and mem_wdata are muxed from the granted requester. With no grant: mem_we=0 and mem_addr holds its last value.
- Priority, evaluated each cycle:
  1. vga_req always wins, including over a locked draw burst and over a starved CPU.
  2. Else if cpu_req and wait_cnt >= MAX_WAIT, the CPU wins, including over a locked draw.
  3. Else if lock_own and draw_req, draw wins.
  4. Else if only one of cpu_req/draw_req is high, that requester wins.
  5. Else if both are high, rr_ptr picks the winner (0 = CPU). After a CPU or draw grant, rr_ptr points to the other requester.
- lock_own:
  - sets on a draw grant with draw_lock=1;
  - clears on any cycle with draw_req=0 or draw_lock=0;
  - is not cleared by a VGA or starvation preemption, so the burst resumes afterwards.
- wait_cnt:
  - increments (saturating at 15) on cycles where cpu_stall=1;
  - clears on cpu_gnt or when cpu_req=0.
- Reads:
  - a read grant (we=0) in cycle n registers an owner tag;
  - in cycle n+1, rdata equals mem_q and exactly one of cpu_rvalid/vga_rvalid pulses;
  - a draw read sets rdata but no rvalid;
  - writes produce no rvalid.
- Simultaneous events: a grant in cycle n+1 can coincide with rvalid for cycle n. Back-to-back reads therefore stream at one per cycle.
- Requesters must hold req, addr and data stable until their grant is seen.
- Reset (reset=0), asynchronous:
  - rr_ptr=0, lock_own=0, wait_cnt=0, owner tag=none;
  - rdata=0, cpu_rvalid=vga_rvalid=0;
  - all gnt outputs and mem_we are forced to 0, and cpu_stall=0, for as long as reset is low.
- A reset asserted mid-burst drops the lock and discards a pending rvalid.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - adds outputs stat_cpu_grants, stat_draw_grants, stat_vga_grants (16 bits each, wrapping) and stat_cpu_stalls (16 bits, saturating at 0xFFFF);
  - all counters clear on reset;
  - adds input stat_clr, which synchronously zeroes all counters and takes precedence over a same-cycle increment.
- When undefined: none of these ports or registers exist, and arbitration behaviour is identical.

Test Plan:
- Reset released with cpu_req=1, cpu_we=0, cpu_addr=0x010, mem_q returning 0xDEADBEEF -> cpu_gnt=1 in the same cycle; next cycle cpu_rvalid=1 and rdata=0xDEADBEEF; cpu_stall stays 0.
- cpu_req and draw_req held high with no lock for 6 cycles -> grants alternate CPU, draw, CPU, draw, CPU, draw; cpu_stall=1 exactly on the draw cycles.
- draw_lock=1 with draw_req and cpu_req held high, MAX_WAIT=4 -> draw is granted while wait_cnt counts 1,2,3,4; the CPU is granted in the cycle after wait_cnt reaches 4; the draw burst then resumes with lock_own still 1.
- vga_req pulsed during a locked draw burst with a starved CPU -> vga_gnt that cycle with cpu_gnt=draw_gnt=0; vga_rvalid next cycle; the following cycle serves the CPU (wait_cnt >= 4).
- Back-to-back reads VGA@0x100, CPU@0x200, VGA@0x101 -> rvalids VGA, CPU, VGA on consecutive cycles with the matching mem_q values; a draw write in between produces no rvalid.
- reset pulled low mid-burst while a read is outstanding -> all gnt outputs, mem_we and rvalid are 0 immediately; after release the lock is gone and round-robin restarts with the CPU first.
